// File: rtl/gpio_irq_if.sv
// rtl/gpio_irq_if.sv - peripheral bus bundle for the gpio input/interrupt block
interface gpio_irq_if;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdt;
    logic        irq;

    modport master (output we, sel, dat, input rdt, irq);
    modport slave  (input we, sel, dat, output rdt, irq);
endinterface

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - synchronised, debounced 8-pin input with edge-detect sticky interrupt
module gpio_irq #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gpi,
    gpio_irq_if.slave  bus
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [7:0]    s0;
    logic [7:0]    s1;
    logic [7:0]    level;
    logic [7:0]    pending;
    logic [7:0]    rise_en;
    logic [7:0]    fall_en;
    logic [7:0]    byp;
    logic          we1;
    logic [CW-1:0] cnt   [8];
    logic [CW-1:0] cnt_n [8];
    logic [7:0]    level_n;
    logic [7:0]    accept;
    logic [7:0]    set_mask;
    logic [7:0]    clr_mask;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            level_n[i] = level[i];
            cnt_n[i]   = cnt[i];
            accept[i]  = 1'b0;
            if (byp[i]) begin
                level_n[i] = s1[i];
                cnt_n[i]   = '0;
                accept[i]  = (s1[i] != level[i]);
            end else if (s1[i] == level[i]) begin
                cnt_n[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                level_n[i] = s1[i];
                cnt_n[i]   = '0;
                accept[i]  = 1'b1;
            end else begin
                cnt_n[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Enables are sampled on the accept cycle; a concurrent W1C loses to the set.
    assign set_mask = accept & ((level_n & rise_en) | (~level_n & fall_en));
    assign clr_mask = (we1 && bus.sel[2]) ? bus.dat[23:16] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0      <= '0;
            s1      <= '0;
            level   <= '0;
            pending <= '0;
            rise_en <= '0;
            fall_en <= '0;
            byp     <= '0;
            we1     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s0      <= gpi;
            s1      <= s0;
            level   <= level_n;
            pending <= (pending & ~clr_mask) | set_mask;
            // The bus holds we for two cycles; only the first produces a strobe.
            we1     <= !we1 && bus.we;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_n[i];
            end
            if (we1) begin
                if (bus.sel[0]) rise_en <= bus.dat[7:0];
                if (bus.sel[1]) fall_en <= bus.dat[15:8];
                if (bus.sel[3]) byp     <= bus.dat[31:24];
            end
        end
    end

    assign bus.rdt = {fall_en, rise_en, pending, level};
    assign bus.irq = |pending;

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - directed table-driven bench for gpio_irq
module tb_gpio_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpi;
    int         checks = 0;
    int         errors = 0;

    gpio_irq_if bus_if ();

    gpio_irq #(.DEB_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .gpi (gpi),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [7:0]  gpi;
        int          cycles;
        logic [31:0] exp_rdt;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [3:0] sel, input logic [31:0] dat);
        bus_if.we  = 1'b1;
        bus_if.sel = sel;
        bus_if.dat = dat;
        tick();
        tick();
        bus_if.we  = 1'b0;
        bus_if.sel = 4'h0;
        bus_if.dat = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [31:0] exp_rdt, input logic exp_irq);
        check({name, ".rdt"}, bus_if.rdt, exp_rdt);
        check({name, ".irq"}, {31'h0, bus_if.irq}, {31'h0, exp_irq});
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0001, 32'h0000_0001, 8'h00, 1, 32'h0001_0000, 1'b0, "rise_en_wr"};
        vecs[1] = '{1'b0, 4'b0000, 32'h0000_0000, 8'h01, 8, 32'h0001_0101, 1'b1, "pin0_rise"};
        vecs[2] = '{1'b1, 4'b0100, 32'h0001_0000, 8'h01, 1, 32'h0001_0001, 1'b0, "w1c_pin0"};
        vecs[3] = '{1'b1, 4'b0011, 32'h0000_0202, 8'h01, 1, 32'h0202_0001, 1'b0, "en_both_wr"};
        vecs[4] = '{1'b0, 4'b0000, 32'h0000_0000, 8'h00, 8, 32'h0202_0000, 1'b0, "pin0_fall_masked"};
        vecs[5] = '{1'b1, 4'b1111, 32'h80FF_4020, 8'h00, 1, 32'h4020_0000, 1'b0, "all_lanes"};
        vecs[6] = '{1'b0, 4'b0000, 32'h0000_0000, 8'h80, 3, 32'h4020_0080, 1'b0, "byp_pin7_rise"};
        vecs[7] = '{1'b0, 4'b0000, 32'h0000_0000, 8'h20, 8, 32'h4020_2020, 1'b1, "pin5_rise"};
        vecs[8] = '{1'b1, 4'b0100, 32'h0020_0000, 8'h20, 1, 32'h4020_0020, 1'b0, "w1c_pin5"};
        vecs[9] = '{1'b1, 4'b1000, 32'h0000_0000, 8'h00, 8, 32'h4020_0000, 1'b0, "byp_off_fall"};

        rst        = 1'b1;
        gpi        = 8'hFF;
        bus_if.we  = 1'b0;
        bus_if.sel = 4'h0;
        bus_if.dat = 32'h0;

        // Reset with pins high: level accepted at the 6th posedge after release
        ticks(3);
        check_bus("in_reset", 32'h0, 1'b0);
        rst = 1'b0;
        ticks(5);
        check_bus("rst_e5", 32'h0, 1'b0);
        tick();
        check_bus("rst_e6", 32'h0000_00FF, 1'b0);
        gpi = 8'h00;
        ticks(8);
        check_bus("rst_low", 32'h0, 1'b0);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].do_wr) bus_write(vecs[v].sel, vecs[v].dat);
            gpi = vecs[v].gpi;
            ticks(vecs[v].cycles);
            check_bus(vecs[v].name, vecs[v].exp_rdt, vecs[v].exp_irq);
        end

        // Glitch rejection on pin 1
        bus_write(4'b0011, 32'h0000_0202);
        gpi = 8'h02;
        ticks(3);
        gpi = 8'h00;
        ticks(8);
        check_bus("glitch3", 32'h0202_0000, 1'b0);
        gpi = 8'h02;
        ticks(4);
        gpi = 8'h00;
        tick();
        check_bus("pulse4_e4", 32'h0202_0000, 1'b0);
        tick();
        check_bus("pulse4_e5", 32'h0202_0202, 1'b1);
        ticks(8);
        check_bus("pulse4_fall", 32'h0202_0200, 1'b1);
        bus_write(4'b0100, 32'h0002_0000);
        check_bus("w1c_pin1", 32'h0202_0000, 1'b0);

        // Bypass on pin 2
        bus_write(4'b1000, 32'h0400_0000);
        bus_write(4'b0001, 32'h0000_0004);
        gpi = 8'h04;
        ticks(2);
        check_bus("byp_e1", 32'h0204_0000, 1'b0);
        tick();
        check_bus("byp_e2", 32'h0204_0404, 1'b1);
        gpi = 8'h00;
        tick();
        gpi = 8'h04;
        ticks(2);
        check_bus("byp_glitch_lo", 32'h0204_0400, 1'b1);
        tick();
        check_bus("byp_glitch_hi", 32'h0204_0404, 1'b1);
        bus_write(4'b1100, 32'h0004_0000);
        check_bus("byp_clr", 32'h0204_0004, 1'b0);

        // Accept on pin 3 coincides with a W1C of pending[3]
        bus_write(4'b0001, 32'h0000_0008);
        gpi = 8'h0C;
        ticks(4);
        check_bus("setwin_pre", 32'h0208_0004, 1'b0);
        bus_write(4'b0100, 32'h0008_0000);
        check_bus("set_wins", 32'h0208_080C, 1'b1);
        bus_write(4'b0100, 32'h0008_0000);
        check_bus("w1c_after", 32'h0208_000C, 1'b0);

        // Multi-lane writes
        bus_write(4'b0110, 32'h00FF_FF00);
        check_bus("sel0110_a", 32'hFF08_000C, 1'b0);
        gpi = 8'h00;
        ticks(8);
        check_bus("fall_23", 32'hFF08_0C00, 1'b1);
        bus_write(4'b0110, 32'h00FF_FF00);
        check_bus("sel0110_b", 32'hFF08_0000, 1'b0);
        gpi = 8'h08;
        ticks(8);
        check_bus("rise_3", 32'hFF08_0808, 1'b1);
        bus_write(4'b1111, 32'h0108_AA55);
        check_bus("sel1111", 32'hAA55_0008, 1'b0);
        gpi = 8'h09;
        ticks(3);
        check_bus("byp_pin0", 32'hAA55_0109, 1'b1);

        // Reset mid-operation with pins held high
        rst = 1'b1;
        tick();
        check_bus("mid_reset", 32'h0, 1'b0);
        rst = 1'b0;
        ticks(8);
        check_bus("post_reset", 32'h0000_0009, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Input-direction companion to the 8-bit GPIO output port.
- Synchronises and debounces 8 input pins.
- Detects rising and falling edges per pin under software-enabled masks.
- Latches sticky pending flags and raises a level interrupt to the CPU.
- Attaches to the peripheral bus with the same write-strobe/byte-lane semantics as the GPIO port.

Parameters:
- DEB_CYCLES, 16: consecutive cycles a synchronised input must differ from the debounced level before the change is accepted. Must be >= 1. Counter width is clog2(DEB_CYCLES), minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  bus write enable; held 2 clock cycles per bus write.
- sel  input  4  byte-lane selects for the write.
- dat  input  32  write data.
- rdt  output  32  read data: [7:0] debounced level, [15:8] pending, [23:16] rise_en, [31:24] fall_en.
- gpi  input  8  asynchronous input pins.
- irq  output  1  interrupt; high while any pending bit is set.

Behaviour:
- Reset (rst high at a posedge) clears to 0: both synchroniser stages, debounce counters, level, pending, rise_en, fall_en, byp, we1. Outputs after reset: rdt=0, irq=0.
- Write pulse: we1 <= !we1 && we. A held 2-cycle we therefore produces exactly one 1-cycle we1. Register updates occur on the posedge where we1=1.
- Write lanes are independent; any combination of lanes may be written in one access:
  - sel[0]: rise_en <= dat[7:0]
  - sel[1]: fall_en <= dat[15:8]
  - sel[2]: pending <= pending & ~dat[23:16] (write-1-to-clear)
  - sel[3]: byp <= dat[31:24] (debounce bypass mask; write-only, not readable)
- Synchroniser: 2 flops per pin. s0 <= gpi, s1 <= s0. Downstream logic uses s1 only.
- Debounce, per pin i with byp[i]=0:
  - If s1[i]==level[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEB_CYCLES-1: level[i] <= s1[i], cnt[i] <= 0 (this is the accept event).
  - Else: cnt[i] <= cnt[i]+1.
- Debounce, per pin with byp[i]=1: level[i] <= s1[i] every cycle, cnt[i] <= 0. An accept event occurs whenever s1[i] != level[i].
- Timing: a gpi change set up before edge E0 appears in s1 after E1. With debounce, level changes at E(DEB_CYCLES+1). With bypass, level changes at E2.
- Glitch rejection: a pulse of fewer than DEB_CYCLES cycles at s1 never changes level. Any return to equality resets the count.
- Edges: on an accept event, rise = new level 1, fall = new level 0.
  - pending[i] is set on the same posedge as the level update if (rise & rise_en[i]) | (fall & fall_en[i]).
  - Enable masks are sampled on that same cycle.
- Set vs clear: if a set and a write-1-to-clear hit the same pin on the same posedge, set wins and the bit stays 1.
- Changing rise_en, fall_en or byp never alters pending. Toggling byp mid-count takes effect next cycle and clears that pin's counter when byp=1.
- irq = |pending, combinational from registered state. No other latency.
- rdt is combinational from registers, valid every cycle regardless of we.
- Reset mid-count or mid-write discards all state. A pin held high through reset produces a level 0->1 accept after reset, but sets no pending because rise_en=0.
- Counter never exceeds DEB_CYCLES-1; no wrap-around is reachable.

Test Plan (DEB_CYCLES=4 unless noted):
- Reset with gpi=8'hFF, rise_en=fall_en=0 -> rdt=0 and irq=0 during reset; level[7:0]=8'hFF at the 6th posedge after reset deassert; pending=0; irq stays 0.
- Write sel=4'b0001, dat[7:0]=8'h01, we held 2 cycles; then gpi[0] 0->1 -> rdt[23:16]=8'h01; level[0]=1 and pending[0]=1 at E5 after the change, irq=1 same cycle; W1C with sel[2], dat[23:16]=8'h01 -> pending=0, irq=0.
- gpi[1] high pulse of 3 cycles with fall_en=rise_en=8'h02 -> level[1] stays 0, pending stays 0. Repeat with a 4-cycle pulse -> level[1] rises then falls; pending[1]=1 after the rise.
- byp=8'h04 written via sel[3], rise_en[2]=1; gpi[2] 0->1 -> level[2]=1 and pending[2]=1 at E2; 1-cycle glitches pass through.
- Force an accept on pin 3 on the exact posedge of a W1C of pending[3] -> pending[3]=1 afterwards (set wins). A W1C one cycle later -> 0.
- Single 2-cycle we with sel=4'b0110, dat=32'h00FF_FF00 -> fall_en=8'hFF and pending cleared, applied exactly once. Repeat with sel=4'b1111 -> all four registers updated in one access.
